// File: rtl/core_mem_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_mem_port_if                                                         |
// | Core request/response bundle plus the core's sh_mem lane.                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface core_mem_port_if #(
  parameter int ADDR_SIZE = 12,
  parameter int REG_SIZE  = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [REG_SIZE-1:0]  req_wdata;
  logic                 resp_valid;
  logic [REG_SIZE-1:0]  resp_rdata;
  logic                 idle;
  logic                 err;
  logic [1:0]           mem_enable;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [REG_SIZE-1:0]  mem_wr_data;
  logic [REG_SIZE-1:0]  mem_rd_data;
  logic                 mem_ready;

  // Port-side view: the memory port itself.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rd_data, mem_ready,
    output req_ready, resp_valid, resp_rdata, idle, err,
           mem_enable, mem_addr, mem_wr_data
  );

  // Driver-side view: the core and sh_mem together.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rd_data, mem_ready,
    input  req_ready, resp_valid, resp_rdata, idle, err,
           mem_enable, mem_addr, mem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/core_mem_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_mem_port                                                            |
// | Per-core request FIFO feeding one sh_mem lane; optional request timeout  |
// | enabled by defining MEM_PORT_TIMEOUT_EN.                                 |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module core_mem_port #(
  parameter int ADDR_SIZE = 12,
  parameter int REG_SIZE  = 8,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255
) (
  input  wire logic      clk,
  input  wire logic      reset,
  core_mem_port_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] EN_NONE  = 2'b00;
  localparam logic [1:0] EN_READ  = 2'b01;
  localparam logic [1:0] EN_WRITE = 2'b10;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("core_mem_port: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_TMO = 2'd2} state_t;
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1} state_t;
`endif

  state_t               state_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 fifo_we_q    [DEPTH];
  logic [ADDR_SIZE-1:0] fifo_addr_q  [DEPTH];
  logic [REG_SIZE-1:0]  fifo_wdata_q [DEPTH];
  logic [1:0]           mem_enable_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [REG_SIZE-1:0]  mem_wr_data_q;
  logic                 resp_valid_q;
  logic [REG_SIZE-1:0]  resp_rdata_q;

  logic                 full, push, pop, more, bypass;
  logic                 nx_we;
  logic [ADDR_SIZE-1:0] nx_addr;
  logic [REG_SIZE-1:0]  nx_wdata;

  assign full = (count_q == CNT_W'(DEPTH));
  assign push = bus.req_valid && !full;
`ifdef MEM_PORT_TIMEOUT_EN
  assign pop  = ((state_q == S_ISSUE) && bus.mem_ready) || (state_q == S_TMO);
`else
  assign pop  = (state_q == S_ISSUE) && bus.mem_ready;
`endif

  // Entries left after this cycle's pop; with one entry stored, a same-cycle
  // push becomes the next head and is forwarded straight from the request.
  assign more     = (count_q > CNT_W'(1)) || push;
  assign bypass   = (count_q == CNT_W'(1));
  assign nxt_ptr  = rd_ptr_q + PTR_W'(1);
  assign nx_we    = bypass ? bus.req_we    : fifo_we_q[nxt_ptr];
  assign nx_addr  = bypass ? bus.req_addr  : fifo_addr_q[nxt_ptr];
  assign nx_wdata = bypass ? bus.req_wdata : fifo_wdata_q[nxt_ptr];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = nxt_ptr;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= bus.req_we;
      fifo_addr_q[wr_ptr_q]  <= bus.req_addr;
      fifo_wdata_q[wr_ptr_q] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mem_enable_q  <= EN_NONE;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
`ifdef MEM_PORT_TIMEOUT_EN
      wait_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q       <= S_ISSUE;
            mem_enable_q  <= fifo_we_q[rd_ptr_q] ? EN_WRITE : EN_READ;
            mem_addr_q    <= fifo_addr_q[rd_ptr_q];
            mem_wr_data_q <= fifo_wdata_q[rd_ptr_q];
`ifdef MEM_PORT_TIMEOUT_EN
            wait_q        <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (bus.mem_ready) begin
            if (mem_enable_q == EN_READ) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= bus.mem_rd_data;
            end
          end
`ifdef MEM_PORT_TIMEOUT_EN
          else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_q      <= S_TMO;
            mem_enable_q <= EN_NONE;
            err_q        <= 1'b1;
            if (mem_enable_q == EN_READ) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
`endif
        end
        default: ;
      endcase
      // Retiring the head overrides the per-state updates above.
      if (pop) begin
        if (more) begin
          state_q       <= S_ISSUE;
          mem_enable_q  <= nx_we ? EN_WRITE : EN_READ;
          mem_addr_q    <= nx_addr;
          mem_wr_data_q <= nx_wdata;
`ifdef MEM_PORT_TIMEOUT_EN
          wait_q        <= '0;
`endif
        end else begin
          state_q      <= S_IDLE;
          mem_enable_q <= EN_NONE;
        end
      end
    end
  end

  assign bus.req_ready   = !full;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.idle        = (state_q == S_IDLE) && (count_q == '0);
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
`ifdef MEM_PORT_TIMEOUT_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_mem_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_mem_port                                                         |
// | Directed self-checking bench for core_mem_port.                          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_core_mem_port;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  core_mem_port_if #(.ADDR_SIZE(12), .REG_SIZE(8)) bus ();

  core_mem_port #(
    .ADDR_SIZE(12),
    .REG_SIZE (8),
    .DEPTH    (4),
    .TIMEOUT  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.mem_rd_data = '0;
    bus.mem_ready   = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_req_ready",  32'(bus.req_ready),   1);
    chk("rst_resp_valid", 32'(bus.resp_valid),  0);
    chk("rst_resp_rdata", 32'(bus.resp_rdata),  0);
    chk("rst_idle",       32'(bus.idle),        1);
    chk("rst_err",        32'(bus.err),         0);
    chk("rst_mem_enable", 32'(bus.mem_enable),  0);
    chk("rst_mem_addr",   32'(bus.mem_addr),    0);
    chk("rst_mem_wdata",  32'(bus.mem_wr_data), 0);
    reset = 1'b1;
    step();

    // Single write with mem_ready stuck high
    bus.mem_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 12'h000;
    bus.req_wdata = 8'd1;
    step();
    bus.req_valid = 1'b0;
    chk("wr_en_push_cycle", 32'(bus.mem_enable), 0);
    chk("wr_idle_busy",     32'(bus.idle),       0);
    step();
    chk("wr_en",    32'(bus.mem_enable),  2);
    chk("wr_addr",  32'(bus.mem_addr),    0);
    chk("wr_wdata", 32'(bus.mem_wr_data), 1);
    step();
    chk("wr_en_done",  32'(bus.mem_enable), 0);
    chk("wr_idle",     32'(bus.idle),       1);
    chk("wr_no_resp",  32'(bus.resp_valid), 0);

    // Read with mem_ready delayed three cycles
    bus.mem_ready   = 1'b0;
    bus.mem_rd_data = 8'd2;
    bus.req_valid   = 1'b1;
    bus.req_we      = 1'b0;
    bus.req_addr    = 12'h101;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rd_en",   32'(bus.mem_enable), 1);
    chk("rd_addr", 32'(bus.mem_addr),   32'h101);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_hold_en",   32'(bus.mem_enable), 1);
      chk("rd_hold_addr", 32'(bus.mem_addr),   32'h101);
      chk("rd_hold_resp", 32'(bus.resp_valid), 0);
    end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("rd_resp_valid", 32'(bus.resp_valid), 1);
    chk("rd_resp_rdata", 32'(bus.resp_rdata), 2);
    chk("rd_en_done",    32'(bus.mem_enable), 0);
    step();
    chk("rd_resp_pulse", 32'(bus.resp_valid), 0);
    chk("rd_rdata_hold", 32'(bus.resp_rdata), 2);
    chk("rd_idle",       32'(bus.idle),       1);

    // Fill the FIFO, then drain back-to-back
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 12'(k);
      bus.req_wdata = 8'(k);
      step();
      if (k == 2) chk("fill_ready_3", 32'(bus.req_ready), 1);
    end
    bus.req_valid = 1'b0;
    chk("fill_full",   32'(bus.req_ready),   0);
    chk("fill_head_en", 32'(bus.mem_enable), 2);
    chk("fill_head",   32'(bus.mem_wr_data), 0);
    bus.mem_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("drain_en",    32'(bus.mem_enable),  2);
      chk("drain_data",  32'(bus.mem_wr_data), 32'(k));
      chk("drain_ready", 32'(bus.req_ready),   1);
    end
    step();
    chk("drain_done_en", 32'(bus.mem_enable), 0);
    chk("drain_idle",    32'(bus.idle),       1);

    // Simultaneous push/pop at count=DEPTH-1 with pointer wrap
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 12'(10 + k);
      bus.req_wdata = 8'(10 + k);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 12'(13 + i);
      bus.req_wdata = 8'(13 + i);
      bus.mem_ready = 1'b1;
      chk("pp_en",    32'(bus.mem_enable),  2);
      chk("pp_data",  32'(bus.mem_wr_data), 32'(10 + i));
      chk("pp_addr",  32'(bus.mem_addr),    32'(10 + i));
      chk("pp_ready", 32'(bus.req_ready),   1);
      step();
    end
    bus.req_valid = 1'b0;
    for (int i = 17; i < 20; i++) begin
      chk("pp_tail_data", 32'(bus.mem_wr_data), 32'(i));
      step();
    end
    chk("pp_done_en", 32'(bus.mem_enable), 0);
    chk("pp_idle",    32'(bus.idle),       1);
    bus.mem_ready = 1'b0;

    // Asynchronous reset in the middle of an issued read
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h3AB;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("arst_pre_en", 32'(bus.mem_enable), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_en",    32'(bus.mem_enable), 0);
    chk("arst_resp",  32'(bus.resp_valid), 0);
    chk("arst_ready", 32'(bus.req_ready),  1);
    bus.mem_ready   = 1'b1;
    bus.mem_rd_data = 8'h55;
    step();
    step();
    reset = 1'b1;
    step();
    chk("arst_post_resp",  32'(bus.resp_valid), 0);
    chk("arst_post_en",    32'(bus.mem_enable), 0);
    chk("arst_post_idle",  32'(bus.idle),       1);
    chk("arst_post_rdata", 32'(bus.resp_rdata), 0);
    step();
    chk("arst_post_resp2", 32'(bus.resp_valid), 0);
    bus.mem_ready = 1'b0;

`ifdef MEM_PORT_TIMEOUT_EN
    // Unserved read times out after TIMEOUT=8 wait cycles
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h222;
    step();
    bus.req_we    = 1'b1;
    bus.req_addr  = 12'h333;
    bus.req_wdata = 8'h44;
    step();
    bus.req_valid = 1'b0;
    chk("tmo_en0", 32'(bus.mem_enable), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("tmo_wait_en",  32'(bus.mem_enable), 1);
      chk("tmo_wait_err", 32'(bus.err),        0);
    end
    step();
    chk("tmo_en",    32'(bus.mem_enable), 0);
    chk("tmo_err",   32'(bus.err),        1);
    chk("tmo_resp",  32'(bus.resp_valid), 1);
    chk("tmo_rdata", 32'(bus.resp_rdata), 0);
    step();
    chk("tmo_next_en",    32'(bus.mem_enable),  2);
    chk("tmo_next_addr",  32'(bus.mem_addr),    32'h333);
    chk("tmo_next_wdata", 32'(bus.mem_wr_data), 32'h44);
    chk("tmo_next_resp",  32'(bus.resp_valid),  0);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("tmo_sticky_err", 32'(bus.err),        1);
    chk("tmo_drain_en",   32'(bus.mem_enable), 0);
`else
    chk("err_tied_low", 32'(bus.err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/core_mem_port.md
# core_mem_port

Per-core memory access port that sits directly upstream of the shared-memory arbitrator `sh_mem`. One instance per core. It queues the core's load/store requests in a small FIFO and presents them one at a time on the core's 2-bit `enable` / `addr` / `wr_data` lane of `sh_mem`. It holds each request stable until `sh_mem` raises that core's `ready`, then returns read data to the core as a one-cycle response pulse.

## Interface
- `ADDR_SIZE`, 12, address width: {4-bit bank, 8-bit offset}.
- `REG_SIZE`, 8, data width.
- `DEPTH`, 4, request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255, max wait cycles for `mem_ready`; used only with `MEM_PORT_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; all state is cleared while it is 0.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: FIFO can accept; equals !full.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_SIZE: request address.
- `req_wdata` in REG_SIZE: write data.
- `resp_valid` out 1: one-cycle pulse; read data valid.
- `resp_rdata` out REG_SIZE: read data; holds its last value between pulses.
- `idle` out 1: FIFO empty and no request on the memory lane.
- `err` out 1: sticky timeout flag; constant 0 without the macro.
- `mem_enable` out 2: to `sh_mem`. 00 = none, 01 = read, 10 = write, 11 is never driven.
- `mem_addr` out ADDR_SIZE: to `sh_mem`.
- `mem_wr_data` out REG_SIZE: to `sh_mem`.
- `mem_rd_data` in REG_SIZE: from `sh_mem`.
- `mem_ready` in 1: from `sh_mem`; the request on the lane is served in the cycle this is high.

## Operation
- **FIFO**
  - Circular buffer of {we, addr, wdata}.
  - `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits.
  - Push on `req_valid && req_ready`. Pop when the head is served or timed out.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - A push while full is impossible because `req_ready`=0.
- **FSM: IDLE**
  - `mem_enable`=00.
  - Moves to ISSUE when `count`>0, loading the head into the registered `mem_*` outputs.
- **FSM: ISSUE**
  - `mem_*` are held stable.
  - On `mem_ready`=1 the head is popped.
  - For a read, `mem_rd_data` is captured into `resp_rdata` and `resp_valid` is pulsed the next cycle. Writes produce no response.
  - After the pop: if entries remain, the next head is loaded into `mem_*` with no bubble and the FSM stays in ISSUE. Otherwise `mem_enable` goes to 00 and the FSM returns to IDLE.
- **FSM: TIMEOUT** (macro only)
  - Entered when the wait counter reaches `TIMEOUT` with `mem_ready`=0.
  - For one cycle: head popped, `err` set to 1, `mem_enable`=00. A read additionally pulses `resp_valid` with `resp_rdata`=0.
  - Then proceeds as for a pop: to ISSUE if entries remain, else to IDLE.
- **`idle`** = (state==IDLE) && `count`==0.
- **Reset**
  - Asserting `reset` mid-request drops `mem_enable` to 00 asynchronously and flushes the FIFO.
  - Any in-flight request is lost; no response is produced for it.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `idle`=1, `err`=0, `mem_enable`=00, `mem_addr`=0, `mem_wr_data`=0. FSM=IDLE, `count`=0, pointers=0.
- Push at edge N → `mem_enable` nonzero from N+1 (FIFO previously empty).
- `mem_ready` high in cycle M → pop at edge M.
  - Read: `resp_valid`=1 during M+1, with `resp_rdata` = the `mem_rd_data` value sampled at edge M.
  - Next queued request appears on the lane in M+1.
- Best-case throughput: one request per cycle when `mem_ready` is held high.
- `mem_*` must not change while in ISSUE and `mem_ready`=0.
- Wait counter: cleared on every load, increments each ISSUE cycle with `mem_ready`=0.

## Configuration
- `MEM_PORT_TIMEOUT_EN` defined:
  - Wait counter and TIMEOUT state are present.
  - A request unserved for `TIMEOUT` cycles is dropped and `err` is set; `err` stays set until reset.
- `MEM_PORT_TIMEOUT_EN` undefined:
  - No counter and no TIMEOUT state; ISSUE waits indefinitely.
  - `err` is tied to 0.

## Test plan
- Reset, then write {4'd0,8'd0}=8'd1 with `mem_ready` stuck high → `mem_enable`=10 one cycle after the push and for exactly one cycle; `idle`=1 afterwards; `resp_valid` stays 0.
- Read {4'd1,8'd1} with `mem_rd_data`=8'd2 and `mem_ready` delayed 3 cycles → `mem_addr`/`mem_enable`=01 stable for 4 cycles; one `resp_valid` pulse with `resp_rdata`=8'd2.
- With `mem_ready`=0, push 4 writes → `req_ready`=0 after the 4th. Release `mem_ready` → writes issued back-to-back with data 0,1,2,3 in order, no bubbles; `req_ready` returns to 1.
- Push and pop in the same cycle while `count`=DEPTH-1 → `count` unchanged; pointer wrap preserves order over 10 requests.
- Assert `reset` mid-ISSUE → `mem_enable`=00 immediately; no `resp_valid`; `idle`=1 after release.
- With `MEM_PORT_TIMEOUT_EN` and `TIMEOUT`=8, read with `mem_ready`=0 → after 8 wait cycles: `err`=1, one `resp_valid` with `resp_rdata`=0, next request issued.
